// File: rtl/prince_ti_pkg.sv
// -----------------------------------------------------------------------------
// prince_ti_pkg
//   Shared sizes and types for the PRINCE threshold-implementation S-layer
//   collection stage.
//     NIBBLES    : nibbles assembled per S-layer pass (64-bit state)
//     EXP_SHARES : expanded shares per S-box output bit from the bit slices
//     BITS       : S-box output bits per nibble
//     slayer_state_t : collection FSM states
//     s1_t       : glitch-barrier register contents (refresh bits + shares)
// -----------------------------------------------------------------------------
package prince_ti_pkg;

  localparam int NIBBLES    = 16;
  localparam int EXP_SHARES = 8;
  localparam int BITS       = 4;

  localparam int IN_W    = BITS * EXP_SHARES;  // 32 expanded share bits
  localparam int STATE_W = NIBBLES * BITS;     // 64-bit shared state
  localparam int ACC_W   = 5;                  // accept counter, counts 0..16
  localparam int WR_W    = 4;                  // write counter, nibble index

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } slayer_state_t;

  // Everything sampled with one accepted nibble. Kept together so the
  // compression only ever sees registered values.
  typedef struct packed {
    logic [BITS-1:0] r;
    logic [IN_W-1:0] shares;
  } s1_t;

endpackage

// File: rtl/prince_ti_slayer_collect_s_bit_compress.sv
// -----------------------------------------------------------------------------
// s_bit_compress
//   Compresses the 8 expanded shares of one S-box output bit down to 2 shares.
//   Shares 0..3 fold into the first output share, shares 4..7 into the second,
//   and the same fresh random bit is XORed into both so the unmasked value
//   (s1 ^ s2) is untouched while the share representation is refreshed.
//   Purely combinational; the caller must feed it from registers only.
//
//   Ports:
//     shares  in  8 : registered expanded shares, index k = share k
//     r       in  1 : registered fresh mask bit
//     s1      out 1 : first compressed share
//     s2      out 1 : second compressed share
// -----------------------------------------------------------------------------
module s_bit_compress
  import prince_ti_pkg::*;
(
  input  logic [EXP_SHARES-1:0] shares,
  input  logic                  r,
  output logic                  s1,
  output logic                  s2
);

  assign s1 = (^shares[3:0]) ^ r;
  assign s2 = (^shares[7:4]) ^ r;

endmodule

// File: rtl/prince_ti_slayer_collect.sv
// -----------------------------------------------------------------------------
// prince_ti_slayer_collect
//   Downstream stage of the PRINCE TI S-box bit slices. Each accepted nibble
//   (4 bits x 8 expanded shares + 4 refresh bits) is registered in S1 as a
//   glitch barrier, compressed to two shares per bit, and written into the
//   next nibble position of two 64-bit accumulators. After 16 nibbles the
//   two-share state is offered to the linear layer.
//
//   Ports:
//     clk        in   1 : clock
//     rst        in   1 : asynchronous active-high reset
//     start      in   1 : begins a pass when idle (ignored otherwise)
//     in_valid   in   1 : in_shares / refresh valid
//     in_ready   out  1 : nibble accepted on in_valid & in_ready
//     in_shares  in  32 : [8b+k] = expanded share k of S-box output bit b
//     refresh    in   4 : fresh random bit per output bit
//     out_valid  out  1 : 64-bit shared state available
//     out_ready  in   1 : consumer takes the state
//     out_share1 out 64 : first output share (accumulator 1)
//     out_share2 out 64 : second output share (accumulator 2)
//     busy       out  1 : FSM not idle
// -----------------------------------------------------------------------------
module prince_ti_slayer_collect
  import prince_ti_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_shares,
  input  logic [BITS-1:0]      refresh,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [STATE_W-1:0]   out_share1,
  output logic [STATE_W-1:0]   out_share2,
  output logic                 busy
);

  slayer_state_t       state_q, state_d;
  s1_t                 s1_q;
  logic                s1_vld_q;
  logic [ACC_W-1:0]    acc_cnt_q;
  logic [WR_W-1:0]     wr_cnt_q;
  logic [STATE_W-1:0]  acc1_q, acc2_q;

  logic                accept;
  logic                start_pass;
  logic                last_write;
  logic [BITS-1:0]     nib1, nib2;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  // Ready stays low once all 16 nibbles are in, even though the FSM only
  // leaves COLLECT one edge later when the last nibble reaches the accumulator.
  assign in_ready   = (state_q == COLLECT) && (acc_cnt_q < ACC_W'(NIBBLES));
  assign accept     = in_valid && in_ready;
  assign start_pass = (state_q == IDLE) && start;
  assign last_write = s1_vld_q && (wr_cnt_q == WR_W'(NIBBLES - 1));

  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Compression, fed from S1 only so no input glitch reaches the share XORs
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < BITS; b++) begin : g_bit
    s_bit_compress u_compress (
      .shares (s1_q.shares[EXP_SHARES*b +: EXP_SHARES]),
      .r      (s1_q.r[b]),
      .s1     (nib1[b]),
      .s2     (nib2[b])
    );
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: state_d gets a default before the case so every path assigns it
    // and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)      state_d = COLLECT;
      COLLECT: if (last_write) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM, S1 glitch barrier and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s1_q      <= '0;
      s1_vld_q  <= 1'b0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values of the others regardless of statement order.
      state_q <= state_d;
      if (start_pass) begin
        acc_cnt_q <= '0;
        wr_cnt_q  <= '0;
        s1_vld_q  <= 1'b0;
      end else begin
        // S1-valid follows the handshake; a gap clears it and stalls the
        // write while S1 and the counters keep their values.
        s1_vld_q <= accept;
        if (accept) begin
          s1_q      <= '{r: refresh, shares: in_shares};
          acc_cnt_q <= acc_cnt_q + ACC_W'(1);
        end
        if (s1_vld_q) begin
          wr_cnt_q <= wr_cnt_q + WR_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulators: nibble i of a pass lands in bits [4i+3:4i]
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these wide registers are reset (not left as uninitialised
      // storage) because the outputs are driven straight from them and must
      // read zero out of reset; a reset mid-pass also drops partial state.
      acc1_q <= '0;
      acc2_q <= '0;
    end else if (s1_vld_q) begin
      acc1_q[{wr_cnt_q, 2'b00} +: BITS] <= nib1;
      acc2_q[{wr_cnt_q, 2'b00} +: BITS] <= nib2;
    end
  end

  // Outputs are not cleared at the start of a pass; they keep the previous
  // result until each nibble position is overwritten.
  assign out_share1 = acc1_q;
  assign out_share2 = acc2_q;

endmodule

// File: tb/tb_prince_ti_slayer_collect.sv
// -----------------------------------------------------------------------------
// tb_prince_ti_slayer_collect
//   Directed bench for prince_ti_slayer_collect. A behavioural model tracks
//   the pass (accepted nibbles, expected shares, phase) from the interface
//   rules; a compare process checks every output on each falling edge, and
//   the directed sequences pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_prince_ti_slayer_collect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_shares = '0;
  logic [3:0]  refresh = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_share1;
  logic [63:0] out_share2;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  prince_ti_slayer_collect dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_shares  (in_shares),
    .refresh    (refresh),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_share1 (out_share1),
    .out_share2 (out_share2),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: phase 0 idle, 1 collecting, 2 result offered.
  // ---------------------------------------------------------------------------
  int          m_phase = 0;
  int          m_acc   = 0;
  int          m_wr    = 0;
  bit          m_pend  = 1'b0;
  logic [3:0]  m_p1 = '0, m_p2 = '0;
  logic [63:0] m_sh1 = '0, m_sh2 = '0;
  int          pass_accepts = 0;

  function automatic logic [3:0] first_share(input logic [31:0] sh, input logic [3:0] r);
    logic [3:0] v;
    for (int b = 0; b < 4; b++) v[b] = sh[8*b] ^ sh[8*b+1] ^ sh[8*b+2] ^ sh[8*b+3] ^ r[b];
    return v;
  endfunction

  function automatic logic [3:0] second_share(input logic [31:0] sh, input logic [3:0] r);
    logic [3:0] v;
    for (int b = 0; b < 4; b++) v[b] = sh[8*b+4] ^ sh[8*b+5] ^ sh[8*b+6] ^ sh[8*b+7] ^ r[b];
    return v;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_phase = 0; m_acc = 0; m_wr = 0; m_pend = 1'b0;
      m_sh1 = '0; m_sh2 = '0;
    end else begin
      bit take;
      int nxt;
      take = (m_phase == 1) && (m_acc < 16) && in_valid;
      nxt  = m_phase;
      if (m_phase == 0) begin
        if (start) begin
          nxt = 1; m_acc = 0; m_wr = 0; m_pend = 1'b0;
        end
      end else begin
        if (m_pend) begin
          m_sh1[4*m_wr +: 4] = m_p1;
          m_sh2[4*m_wr +: 4] = m_p2;
          m_wr++;
          if (m_wr == 16) nxt = 2;
        end
        if (m_phase == 2 && out_ready) nxt = 0;
        m_pend = take;
        if (take) begin
          m_p1 = first_share(in_shares, refresh);
          m_p2 = second_share(in_shares, refresh);
          m_acc++;
        end
      end
      m_phase = nxt;
    end
  end

  // Accepts seen on the interface, used to confirm exactly 16 per pass.
  initial forever begin
    @(posedge clk);
    if (!rst && in_valid && in_ready) pass_accepts++;
  end

  // Compare process: every falling edge outside reset.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("in_ready",   64'(in_ready),  64'((m_phase == 1) && (m_acc < 16)));
      check("out_valid",  64'(out_valid), 64'(m_phase == 2));
      check("busy",       64'(busy),      64'(m_phase != 0));
      check("out_share1", out_share1, m_sh1);
      check("out_share2", out_share2, m_sh2);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Nibble i encoded as expanded shares. Plain: bit b of i in share 0.
  // Alternate: bit b in share 5, plus an equal pair in shares 1 and 6 so the
  // two compressed shares differ while their XOR is still bit b of i.
  function automatic logic [31:0] mk(input int i, input bit alt);
    logic [31:0] v;
    logic [3:0]  n;
    v = '0;
    n = 4'(i);
    for (int b = 0; b < 4; b++) begin
      if (!alt) begin
        v[8*b] = n[b];
      end else begin
        v[8*b+5] = n[b];
        if (((i + b) % 2) == 1) begin
          v[8*b+1] = 1'b1;
          v[8*b+6] = 1'b1;
        end
      end
    end
    return v;
  endfunction

  // One pass. Returns the cycle number (1 = cycle right after the start edge)
  // in which out_valid was first seen high.
  task automatic run_pass(input bit use_refresh, input bit gapped,
                          input bit spurious, input int hold, output int ov_cycle);
    logic [15:0] gap_pat;
    int cyc;
    int to;
    gap_pat = 16'b0100_1011_0010_0110;
    pass_accepts = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    for (int i = 0; i < 16; i++) begin
      in_valid  = 1'b1;
      in_shares = mk(i, gapped);
      refresh   = use_refresh ? 4'hF : 4'h0;
      to = 0;
      while (!in_ready && to < 50) begin
        tick(); cyc++; to++;
      end
      if (to >= 50) check("in_ready_timeout", 64'(in_ready), 64'd1);
      if (spurious && i == 5) start = 1'b1;
      tick(); cyc++;
      start = 1'b0;
      if (gapped && gap_pat[i]) begin
        in_valid = 1'b0;
        in_shares = 32'hFFFF_FFFF;
        tick(); cyc++;
        if (i % 3 == 0) begin
          tick(); cyc++;
        end
      end
    end
    // Keep offering data after the 16th accept: nothing more may be taken.
    in_valid  = 1'b1;
    in_shares = 32'hA5A5_A5A5;
    check("ready_after_16", 64'(in_ready), 64'd0);
    to = 0;
    while (!out_valid && to < 50) begin
      tick(); cyc++; to++;
    end
    in_valid = 1'b0;
    if (to >= 50) check("out_valid_timeout", 64'(out_valid), 64'd1);
    ov_cycle = cyc;
    check("accept_count", 64'(pass_accepts), 64'd16);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) tick();
    check("valid_after_hold", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    if (spurious) start = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    check("idle_after_handshake", 64'(busy), 64'd0);
    check("valid_after_handshake", 64'(out_valid), 64'd0);
    tick(); tick();
    check("still_idle", 64'(busy), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int ovc;

    // Reset state
    tick(); tick();
    check("rst_out_share1", out_share1, 64'd0);
    check("rst_out_share2", out_share2, 64'd0);
    check("rst_in_ready",   64'(in_ready),  64'd0);
    check("rst_out_valid",  64'(out_valid), 64'd0);
    check("rst_busy",       64'(busy),      64'd0);
    rst = 1'b0;
    tick();

    // Basic pass, no refresh, back-to-back
    run_pass(1'b0, 1'b0, 1'b0, 0, ovc);
    check("basic_latency", 64'(ovc), 64'd18);
    check("basic_share1",  out_share1, 64'hFEDC_BA98_7654_3210);
    check("basic_share2",  out_share2, 64'd0);

    // Idle input without start: nothing accepted, outputs retained
    in_valid  = 1'b1;
    in_shares = 32'hFFFF_FFFF;
    refresh   = 4'hF;
    for (int k = 0; k < 5; k++) begin
      check("idle_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    check("idle_share1", out_share1, 64'hFEDC_BA98_7654_3210);
    check("idle_share2", out_share2, 64'd0);

    // Refresh all ones
    run_pass(1'b1, 1'b0, 1'b0, 0, ovc);
    check("refresh_latency", 64'(ovc), 64'd18);
    check("refresh_xor",    out_share1 ^ out_share2, 64'hFEDC_BA98_7654_3210);
    check("refresh_share2", out_share2, 64'hFFFF_FFFF_FFFF_FFFF);
    check("refresh_share1", out_share1, 64'h0123_4567_89AB_CDEF);

    // Gaps, back-pressure and spurious start pulses
    run_pass(1'b0, 1'b1, 1'b1, 10, ovc);
    check("gap_xor", out_share1 ^ out_share2, 64'hFEDC_BA98_7654_3210);

    // Reset after nibble 7
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      in_shares = mk(i, 1'b0);
      refresh   = 4'h5;
      tick();
    end
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("midrst_share1",    out_share1, 64'd0);
    check("midrst_share2",    out_share2, 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy",      64'(busy),      64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", 64'(busy), 64'd0);

    // Full pass after reset: no stale nibbles
    run_pass(1'b0, 1'b0, 1'b0, 0, ovc);
    check("post_rst_latency", 64'(ovc), 64'd18);
    check("post_rst_share1",  out_share1, 64'hFEDC_BA98_7654_3210);
    check("post_rst_share2",  out_share2, 64'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
